// File: rtl/tap_read_scheduler.sv
// Per-sample delay-line sequencer: writes the new sample into the single-port RAM, fetches the
// chorus and reverb taps, then holds all three samples stable through the MCU SPI handshake.
module tap_read_scheduler #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              transmit,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              chor_en,
  input  logic              rev_en,
  input  logic [ADDR_W-1:0] chor_dly,
  input  logic [ADDR_W-1:0] rev_dly,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] main_smp,
  output logic [DATA_W-1:0] chor_smp,
  output logic [DATA_W-1:0] rev_smp,
  output logic              tfr_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    StIdle, StWrMain, StRdChor, StWaitChor, StRdRev, StWaitRev, StReady, StMcuWait, StMcuSpi
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, chor_dly_q, rev_dly_q;
  logic              chor_en_q, rev_en_q;
  logic [DATA_W-1:0] main_q, chor_q, rev_q;
  logic              overrun_q;
  logic              wait_done;
  logic [ADDR_W-1:0] chor_adr, rev_adr;

  assign wait_done = (cnt_q == CntW'(RD_LAT - 1));
  // Modular subtraction gives the circular-buffer wrap for free.
  assign chor_adr  = wr_ptr_q - chor_dly_q;
  assign rev_adr   = wr_ptr_q - rev_dly_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    mem_adr   = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StWrMain;
      end
      StWrMain: begin
        mem_adr   = wr_ptr_q;
        mem_we    = 1'b1;
        mem_wdata = main_q;
        if (chor_en_q)     state_d = StRdChor;
        else if (rev_en_q) state_d = StRdRev;
        else               state_d = StReady;
      end
      StRdChor: begin
        mem_adr = chor_adr;
        state_d = StWaitChor;
      end
      StWaitChor: begin
        mem_adr = chor_adr;
        if (wait_done) state_d = rev_en_q ? StRdRev : StReady;
        else           cnt_d   = cnt_q + CntW'(1);
      end
      StRdRev: begin
        mem_adr = rev_adr;
        state_d = StWaitRev;
      end
      StWaitRev: begin
        mem_adr = rev_adr;
        if (wait_done) state_d = StReady;
        else           cnt_d   = cnt_q + CntW'(1);
      end
      StReady: begin
        state_d = StMcuWait;
      end
      StMcuWait: begin
        if (!transmit) state_d = StMcuSpi;
      end
      StMcuSpi: begin
        if (transmit) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      chor_dly_q <= '0;
      rev_dly_q  <= '0;
      chor_en_q  <= 1'b0;
      rev_en_q   <= 1'b0;
      main_q     <= '0;
      chor_q     <= '0;
      rev_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && start) begin
        main_q     <= sample_in;
        chor_dly_q <= chor_dly;
        rev_dly_q  <= rev_dly;
        chor_en_q  <= chor_en;
        rev_en_q   <= rev_en;
        if (!chor_en) chor_q <= '0;
        if (!rev_en)  rev_q  <= '0;
      end
      if (state_q == StWaitChor && wait_done) chor_q <= mem_rdata;
      if (state_q == StWaitRev && wait_done)  rev_q  <= mem_rdata;
      if (state_q == StMcuSpi && transmit)    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (start && state_q != StIdle)         overrun_q <= 1'b1;
    end
  end

  assign main_smp  = main_q;
  assign chor_smp  = chor_q;
  assign rev_smp   = rev_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);
  assign tfr_ready = (state_q == StReady) || (state_q == StMcuWait);

endmodule

// File: tb/tb_tap_read_scheduler.sv
// Bench for tap_read_scheduler: two instances (read latency 1 and 3) driven in lockstep, each
// with its own RAM, compared against an array model of the circular delay line.
module tb_tap_read_scheduler;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned LA    = 1;
  localparam int unsigned LB    = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          transmit = 1'b1;
  logic          chor_en = 1'b0;
  logic          rev_en = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [AW-1:0] chor_dly = '0;
  logic [AW-1:0] rev_dly = '0;

  logic [AW-1:0] adr_a, adr_b;
  logic          we_a, we_b, tfr_a, tfr_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [DW-1:0] wd_a, wd_b, rd_a, rd_b, main_a, main_b, chor_a, chor_b, rev_a, rev_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tap_read_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LA)) dut_a (
    .clk(clk), .reset(reset), .start(start), .transmit(transmit), .sample_in(sample_in),
    .chor_en(chor_en), .rev_en(rev_en), .chor_dly(chor_dly), .rev_dly(rev_dly),
    .mem_adr(adr_a), .mem_we(we_a), .mem_wdata(wd_a), .mem_rdata(rd_a),
    .main_smp(main_a), .chor_smp(chor_a), .rev_smp(rev_a),
    .tfr_ready(tfr_a), .busy(busy_a), .overrun(ovr_a)
  );

  tap_read_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LB)) dut_b (
    .clk(clk), .reset(reset), .start(start), .transmit(transmit), .sample_in(sample_in),
    .chor_en(chor_en), .rev_en(rev_en), .chor_dly(chor_dly), .rev_dly(rev_dly),
    .mem_adr(adr_b), .mem_we(we_b), .mem_wdata(wd_b), .mem_rdata(rd_b),
    .main_smp(main_b), .chor_smp(chor_b), .rev_smp(rev_b),
    .tfr_ready(tfr_b), .busy(busy_b), .overrun(ovr_b)
  );

  // RAM models: preloaded with RAM[k]=k on the first edge, read data delayed by the latency.
  logic [DW-1:0] ram_a [DEPTH];
  logic [DW-1:0] ram_b [DEPTH];
  logic [DW-1:0] pipe_a [LA];
  logic [DW-1:0] pipe_b [LB];
  logic          ram_init = 1'b0;
  int            wr_cnt_a = 0;
  int            wr_cnt_b = 0;
  logic [AW-1:0] last_wa_a, last_wa_b;
  logic [DW-1:0] last_wd_a, last_wd_b;

  assign rd_a = pipe_a[LA-1];
  assign rd_b = pipe_b[LB-1];

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int k = 0; k < DEPTH; k++) begin
        ram_a[k] <= DW'(k);
        ram_b[k] <= DW'(k);
      end
      ram_init <= 1'b1;
    end else begin
      if (we_a) begin
        ram_a[adr_a] <= wd_a;
        wr_cnt_a     <= wr_cnt_a + 1;
        last_wa_a    <= adr_a;
        last_wd_a    <= wd_a;
      end
      if (we_b) begin
        ram_b[adr_b] <= wd_b;
        wr_cnt_b     <= wr_cnt_b + 1;
        last_wa_b    <= adr_b;
        last_wd_b    <= wd_b;
      end
    end
    pipe_a[0] <= ram_a[adr_a];
    pipe_b[0] <= ram_b[adr_b];
    for (int i = 1; i < LA; i++) pipe_a[i] <= pipe_a[i-1];
    for (int i = 1; i < LB; i++) pipe_b[i] <= pipe_b[i-1];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned   ptr = 0;
  logic          exp_ovr = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [DW-1:0] smp, input logic [AW-1:0] cd,
                          input logic [AW-1:0] rd, input logic ce, input logic re,
                          input bit ovr_inj);
    int            wc_a, wc_b, lat_a, lat_b, el_a, el_b;
    logic [AW-1:0] ca, ra, lrd;
    logic [DW-1:0] ec, er;
    wc_a = wr_cnt_a;
    wc_b = wr_cnt_b;
    sample_in = smp; chor_dly = cd; rev_dly = rd; chor_en = ce; rev_en = re;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble inputs: the frame must run on the values latched with start.
    sample_in = DW'($urandom); chor_dly = AW'($urandom); rev_dly = AW'($urandom);
    chor_en = ~ce; rev_en = ~re;
    lat_a = 0; lat_b = 0; lrd = '0;
    for (int n = 1; n <= 60; n++) begin
      if (busy_a && !we_a && !tfr_a) lrd = adr_a;
      if (tfr_a && lat_a == 0) lat_a = n;
      if (tfr_b && lat_b == 0) lat_b = n;
      if (lat_a != 0 && lat_b != 0) break;
      tick();
    end
    ref_mem[ptr] = smp;
    ca = AW'(ptr) - cd;
    ra = AW'(ptr) - rd;
    ec = ce ? ref_mem[ca] : '0;
    er = re ? ref_mem[ra] : '0;
    el_a = 2 + (ce ? 1 + LA : 0) + (re ? 1 + LA : 0);
    el_b = 2 + (ce ? 1 + LB : 0) + (re ? 1 + LB : 0);
    check("latency_a", 32'(lat_a), 32'(el_a));
    check("latency_b", 32'(lat_b), 32'(el_b));
    check("main_a", 32'(main_a), 32'(smp));
    check("main_b", 32'(main_b), 32'(smp));
    check("chor_a", 32'(chor_a), 32'(ec));
    check("chor_b", 32'(chor_b), 32'(ec));
    check("rev_a", 32'(rev_a), 32'(er));
    check("rev_b", 32'(rev_b), 32'(er));
    check("writes_a", 32'(wr_cnt_a - wc_a), 32'd1);
    check("writes_b", 32'(wr_cnt_b - wc_b), 32'd1);
    check("wr_adr_a", 32'(last_wa_a), 32'(ptr));
    check("wr_adr_b", 32'(last_wa_b), 32'(ptr));
    check("wr_data_a", 32'(last_wd_a), 32'(smp));
    if (re)      check("rd_adr_rev", 32'(lrd), 32'(ra));
    else if (ce) check("rd_adr_chor", 32'(lrd), 32'(ca));
    tick();
    check("hold_ready_a", 32'(tfr_a), 32'd1);
    check("hold_ready_b", 32'(tfr_b), 32'd1);
    if (ovr_inj) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_ovr = 1'b1;
      check("ovr_ready_a", 32'(tfr_a), 32'd1);
    end
    check("overrun_a", 32'(ovr_a), 32'(exp_ovr));
    check("overrun_b", 32'(ovr_b), 32'(exp_ovr));
    transmit = 1'b0;
    tick();
    tick();
    check("spi_ready_a", 32'(tfr_a), 32'd0);
    check("spi_busy_b", 32'(busy_b), 32'd1);
    transmit = 1'b1;
    tick();
    check("idle_a", 32'(busy_a), 32'd0);
    check("idle_b", 32'(busy_b), 32'd0);
    check("held_main_a", 32'(main_a), 32'(smp));
    check("held_rev_b", 32'(rev_b), 32'(er));
    ptr = (ptr + 1) % DEPTH;
  endtask

  initial begin
    int wc;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = DW'(k);
    repeat (3) tick();
    check("rst_main", 32'(main_a), 32'd0);
    check("rst_chor", 32'(chor_a), 32'd0);
    check("rst_rev", 32'(rev_b), 32'd0);
    check("rst_adr", 32'(adr_a), 32'd0);
    check("rst_wdata", 32'(wd_a), 32'd0);
    check("rst_we", 32'({we_a, we_b}), 32'd0);
    check("rst_flags", 32'({tfr_a, busy_a, ovr_a}), 32'd0);
    reset = 1'b1;
    tick();

    // Single frame with both taps off.
    do_frame(16'h1234, '0, '0, 1'b0, 1'b0, 1'b0);

    // Advance the pointer to 10 keeping RAM[k]=k, then fetch both taps.
    while (ptr != 10) do_frame(DW'(ptr), AW'($urandom), AW'($urandom), 1'b0, 1'b0, 1'b0);
    do_frame(16'hA5A5, AW'(3), AW'(7), 1'b1, 1'b1, 1'b0);
    check("t2_chor_val", 32'(chor_a), 32'd7);
    check("t2_rev_val", 32'(rev_b), 32'd3);

    // Start during MCU_WAIT is ignored but flagged.
    do_frame(DW'($urandom), AW'($urandom), AW'($urandom), 1'b1, 1'b1, 1'b1);

    for (int f = 0; f < 40; f++)
      do_frame(DW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0));

    // Wrap the pointer round to 2 for the modular-address case.
    while (ptr != 2) do_frame(DW'($urandom), '0, '0, 1'b0, 1'b0, 1'b0);
    do_frame(16'h5A5A, AW'(0), AW'(5), 1'b1, 1'b1, 1'b0);
    check("t3_chor_eq_main", 32'(chor_a), 32'(main_a));

    // Reset in the middle of the chorus wait.
    sample_in = 16'hBEEF; chor_en = 1'b1; rev_en = 1'b1; chor_dly = AW'(1); rev_dly = AW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    wc = wr_cnt_a;
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_main", 32'(main_a), 32'd0);
    check("mid_rst_smp", 32'({chor_a, rev_b}), 32'd0);
    check("mid_rst_mem", 32'({we_a, we_b, adr_a}), 32'd0);
    check("mid_rst_flags", 32'({tfr_a, busy_a, busy_b, ovr_a, ovr_b}), 32'd0);
    ref_mem[ptr] = 16'hBEEF;
    ptr = 0;
    exp_ovr = 1'b0;
    repeat (3) tick();
    check("rst_no_write", 32'(wr_cnt_a - wc), 32'd0);
    reset = 1'b1;
    tick();
    do_frame(DW'($urandom), AW'($urandom), AW'($urandom), 1'b1, 1'b1, 1'b0);
    for (int f = 0; f < 10; f++)
      do_frame(DW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
